// File: rtl/shift_pkg.sv
// Shared types for the shift sequencing stage.
//   shift_op_t : request opcode (SLL, SRL, SRA, illegal)
//   result_t   : one result FIFO entry (data plus flags captured at push time)
package shift_pkg;

    localparam int unsigned SHIFT_W = 32;

    typedef enum logic [1:0] {
        SHIFT_SLL     = 2'b00,
        SHIFT_SRL     = 2'b01,
        SHIFT_SRA     = 2'b10,
        SHIFT_ILLEGAL = 2'b11
    } shift_op_t;

    typedef struct packed {
        logic [SHIFT_W-1:0] data;
        logic               zero;
        logic               illegal;
    } result_t;

    // Flags are derived here, once, so the FIFO head never needs a compare.
    function automatic result_t make_result(input logic [SHIFT_W-1:0] data,
                                            input logic               illegal);
        result_t r;
        r.data    = data;
        r.zero    = (data == '0);
        r.illegal = illegal;
        return r;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Two-entry synchronous FIFO of result_t.
//   clk, rst     : clock, asynchronous active-low reset
//   push_i       : write push_data_i at the tail
//   push_data_i  : entry to write
//   pop_i        : drop the head (ignored when empty)
//   head_o       : current head entry
//   valid_o      : FIFO non-empty
//   count_o      : number of stored entries (0..2)
module result_fifo
    import shift_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  result_t    push_data_i,
    input  logic       pop_i,
    output result_t    head_o,
    output logic       valid_o,
    output logic [1:0] count_o
);

    result_t    mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    logic do_push;
    logic do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full FIFO is only taken when the head leaves the same cycle.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 2'd1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/shift_sequencer.sv
// Sequencing stage around the three 32-bit combinational shifters.
// Registers a request, holds operand/shamt stable on sh_in/sh_shamt for
// SETTLE_CYCLES so the shifters may be a multicycle path, then captures the
// selected shifter result into a 2-entry result FIFO.
//   clk, rst                    : clock, asynchronous active-low reset
//   i_valid/i_ready             : request handshake
//   i_op, i_data, i_shamt       : request opcode, operand, shift amount
//   sh_in, sh_shamt             : registered operand/shamt to all shifters
//   sll_out, srl_out, sra_out   : shifter results
//   o_valid/o_ready             : result handshake
//   o_data, o_zero, o_illegal   : head result and its flags
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned N             = 32,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [1:0]   i_op,
    input  logic [N-1:0] i_data,
    input  logic [4:0]   i_shamt,
    output logic [N-1:0] sh_in,
    output logic [4:0]   sh_shamt,
    input  logic [N-1:0] sll_out,
    input  logic [N-1:0] srl_out,
    input  logic [N-1:0] sra_out,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] o_data,
    output logic         o_zero,
    output logic         o_illegal
);

    typedef enum logic {StIdle, StSettle} state_e;

    localparam logic [2:0] SettleInit = 3'(SETTLE_CYCLES - 1);
    localparam logic [1:0] FifoDepth  = 2'(FIFO_DEPTH);

    state_e          state_q;
    logic [2:0]      cnt_q;
    shift_op_t       op_q;
    logic [N-1:0]    sh_in_q;
    logic [4:0]      sh_shamt_q;

    logic            accept;
    logic            fast;
    logic [N-1:0]    sel_out;
    logic            push;
    result_t         push_data;
    result_t         head;
    logic [1:0]      fifo_count;

    // Gated by rst so the request side is closed for the whole reset window.
    assign i_ready = rst && (state_q == StIdle) && (fifo_count < FifoDepth);
    assign accept  = i_valid && i_ready;
    // Zero shift and illegal ops bypass the shifters entirely.
    assign fast    = (i_shamt == 5'd0) || (shift_op_t'(i_op) == SHIFT_ILLEGAL);

    always_comb begin
        sel_out = sll_out;
        unique case (op_q)
            SHIFT_SRL: sel_out = srl_out;
            SHIFT_SRA: sel_out = sra_out;
            default:   sel_out = sll_out;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (state_q == StIdle) begin
            if (accept && fast) begin
                push      = 1'b1;
                push_data = make_result(i_data, shift_op_t'(i_op) == SHIFT_ILLEGAL);
            end
        end else if (cnt_q == 3'd0) begin
            push      = 1'b1;
            push_data = make_result(sel_out, 1'b0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            op_q       <= SHIFT_SLL;
            sh_in_q    <= '0;
            sh_shamt_q <= 5'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q       <= shift_op_t'(i_op);
                        sh_in_q    <= i_data;
                        sh_shamt_q <= i_shamt;
                        if (!fast) begin
                            cnt_q   <= SettleInit;
                            state_q <= StSettle;
                        end
                    end
                end
                StSettle: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    result_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (o_ready),
        .head_o      (head),
        .valid_o     (o_valid),
        .count_o     (fifo_count)
    );

    assign sh_in     = sh_in_q;
    assign sh_shamt  = sh_shamt_q;
    assign o_data    = head.data;
    assign o_zero    = head.zero;
    assign o_illegal = head.illegal;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: one instance with SETTLE_CYCLES=1 and one
// with SETTLE_CYCLES=3, each closed around behavioural shifter models.
module tb_shift_sequencer;

    logic clk;
    logic rst;

    // SETTLE_CYCLES = 1 instance
    logic        v1, r1, ov1, ordy1, oz1, oi1;
    logic [1:0]  op1;
    logic [31:0] d1, sin1, sll1, srl1, sra1, od1;
    logic [4:0]  s1, ssh1;

    // SETTLE_CYCLES = 3 instance
    logic        v3, r3, ov3, ordy3, oz3, oi3;
    logic [1:0]  op3;
    logic [31:0] d3, sin3, sll3, srl3, sra3, od3;
    logic [4:0]  s3, ssh3;

    int n_checks = 0;
    int n_fail   = 0;

    assign sll1 = sin1 << ssh1;
    assign srl1 = sin1 >> ssh1;
    assign sra1 = $unsigned($signed(sin1) >>> ssh1);
    assign sll3 = sin3 << ssh3;
    assign srl3 = sin3 >> ssh3;
    assign sra3 = $unsigned($signed(sin3) >>> ssh3);

    shift_sequencer #(.N(32), .SETTLE_CYCLES(1), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .i_valid(v1), .i_ready(r1), .i_op(op1), .i_data(d1),
        .i_shamt(s1), .sh_in(sin1), .sh_shamt(ssh1), .sll_out(sll1), .srl_out(srl1),
        .sra_out(sra1), .o_valid(ov1), .o_ready(ordy1), .o_data(od1), .o_zero(oz1),
        .o_illegal(oi1)
    );

    shift_sequencer #(.N(32), .SETTLE_CYCLES(3), .FIFO_DEPTH(2)) dut3 (
        .clk(clk), .rst(rst), .i_valid(v3), .i_ready(r3), .i_op(op3), .i_data(d3),
        .i_shamt(s3), .sh_in(sin3), .sh_shamt(ssh3), .sll_out(sll3), .srl_out(srl3),
        .sra_out(sra3), .o_valid(ov3), .o_ready(ordy3), .o_data(od3), .o_zero(oz3),
        .o_illegal(oi3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    // One request on the SETTLE_CYCLES=1 instance with o_ready high.
    task automatic run1(input vec_t v, input int idx);
        int lat;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!r1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("vec%0d_ready", idx), {31'd0, r1}, 32'd1);
        op1 = v.op;
        d1  = v.data;
        s1  = v.shamt;
        v1  = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
        lat = 1;
        while (!ov1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("vec%0d_data", idx), od1, v.exp_data);
        chk($sformatf("vec%0d_zero", idx), {31'd0, oz1}, {31'd0, v.exp_zero});
        chk($sformatf("vec%0d_illegal", idx), {31'd0, oi1}, {31'd0, v.exp_ill});
        chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        @(posedge clk);
        #1;
    endtask

    task automatic issue1(input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!r1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_issue_ready", {31'd0, r1}, 32'd1);
        op1 = op;
        d1  = data;
        s1  = sh;
        v1  = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
    endtask

    initial begin
        int          lat;
        int          got;
        int          guard;
        logic        stale;
        logic [31:0] res [2];

        vecs[0] = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0, 2};
        vecs[1] = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0, 2};
        vecs[2] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 2};
        vecs[3] = '{2'b00, 32'h0000_0002, 5'd31, 32'h0000_0000, 1'b1, 1'b0, 2};
        vecs[4] = '{2'b10, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0, 1};
        vecs[5] = '{2'b11, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1'b0, 1'b1, 1};
        vecs[6] = '{2'b00, 32'h0000_0000, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[7] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1, 1'b0, 2};
        vecs[8] = '{2'b10, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 2};

        rst = 1'b0;
        v1 = 1'b0; op1 = 2'b00; d1 = '0; s1 = '0; ordy1 = 1'b1;
        v3 = 1'b0; op3 = 2'b00; d3 = '0; s3 = '0; ordy3 = 1'b1;

        // Reset state
        #12;
        chk("rst_i_ready", {31'd0, r1}, 32'd0);
        chk("rst_o_valid", {31'd0, ov1}, 32'd0);
        chk("rst_o_data", od1, 32'd0);
        chk("rst_o_zero", {31'd0, oz1}, 32'd0);
        chk("rst_o_illegal", {31'd0, oi1}, 32'd0);
        chk("rst_sh_in", sin1, 32'd0);
        chk("rst_sh_shamt", {27'd0, ssh1}, 32'd0);
        chk("rst_i_ready3", {31'd0, r3}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("post_rst_i_ready", {31'd0, r1}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            run1(vecs[i], i);
        end

        // Backpressure: two results fill the FIFO, third waits for a pop.
        ordy1 = 1'b0;
        issue1(2'b01, 32'h0000_00F0, 5'd4);
        @(posedge clk);
        issue1(2'b01, 32'h0000_FF00, 5'd8);
        @(posedge clk);
        @(negedge clk);
        chk("bp_full_ready", {31'd0, r1}, 32'd0);
        chk("bp_head_a", od1, 32'h0000_000F);
        op1 = 2'b01;
        d1  = 32'hABCD_0000;
        s1  = 5'd16;
        v1  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_still_blocked", {31'd0, r1}, 32'd0);
        chk("bp_head_stable", od1, 32'h0000_000F);
        chk("bp_valid_held", {31'd0, ov1}, 32'd1);
        ordy1 = 1'b1;
        @(posedge clk);
        #1 ordy1 = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_pop", {31'd0, r1}, 32'd1);
        @(posedge clk);
        #1 v1 = 1'b0;
        chk("bp_head_b", od1, 32'h0000_00FF);
        ordy1 = 1'b1;
        got   = 0;
        guard = 0;
        while (got < 2 && guard < 30) begin
            @(negedge clk);
            if (ov1) begin
                res[got] = od1;
                got++;
            end
            @(posedge clk);
            guard++;
        end
        chk("bp_result_count", 32'(got), 32'd2);
        chk("bp_order_b", res[0], 32'h0000_00FF);
        chk("bp_order_c", res[1], 32'h0000_ABCD);

        // SETTLE_CYCLES=3: inputs held, request side closed, latency 4.
        @(negedge clk);
        chk("s3_ready_idle", {31'd0, r3}, 32'd1);
        op3 = 2'b01;
        d3  = 32'h8000_0000;
        s3  = 5'd4;
        v3  = 1'b1;
        @(posedge clk);
        #1;
        d3 = 32'hFFFF_FFFF;
        s3 = 5'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("s3_ready_low%0d", i), {31'd0, r3}, 32'd0);
            chk($sformatf("s3_sh_in%0d", i), sin3, 32'h8000_0000);
            chk($sformatf("s3_sh_shamt%0d", i), {27'd0, ssh3}, 32'd4);
            chk($sformatf("s3_no_valid%0d", i), {31'd0, ov3}, 32'd0);
            if (i == 2) v3 = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("s3_valid_lat4", {31'd0, ov3}, 32'd1);
        chk("s3_data", od3, 32'h0800_0000);
        chk("s3_zero", {31'd0, oz3}, 32'd0);
        @(posedge clk);
        #1;
        chk("s3_sh_in_held", sin3, 32'h8000_0000);
        chk("s3_popped", {31'd0, ov3}, 32'd0);

        // Reset in the middle of SETTLE with a result already queued.
        ordy3 = 1'b0;
        @(negedge clk);
        op3 = 2'b11;
        d3  = 32'hDEAD_BEEF;
        s3  = 5'd5;
        v3  = 1'b1;
        @(posedge clk);
        #1 v3 = 1'b0;
        chk("rs_fast_valid", {31'd0, ov3}, 32'd1);
        chk("rs_fast_illegal", {31'd0, oi3}, 32'd1);
        @(negedge clk);
        op3 = 2'b00;
        d3  = 32'h0000_0001;
        s3  = 5'd3;
        v3  = 1'b1;
        @(posedge clk);
        #1 v3 = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rs_valid_cleared", {31'd0, ov3}, 32'd0);
        chk("rs_ready_low", {31'd0, r3}, 32'd0);
        chk("rs_sh_in_cleared", sin3, 32'd0);
        chk("rs_o_data_cleared", od3, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rs_ready_after", {31'd0, r3}, 32'd1);
        stale = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ov3) stale = 1'b1;
        end
        chk("rs_no_stale", {31'd0, stale}, 32'd0);

        ordy3 = 1'b1;
        @(negedge clk);
        op3 = 2'b00;
        d3  = 32'h0000_0001;
        s3  = 5'd3;
        v3  = 1'b1;
        @(posedge clk);
        #1 v3 = 1'b0;
        lat = 1;
        while (!ov3 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rs_fresh_data", od3, 32'h0000_0008);
        chk("rs_fresh_latency", 32'(lat), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
